// File: rtl/counter_launcher_if.sv
// ============================================================================
// counter_launcher_if : button / go-done handshake bundle for counter_launcher
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

interface counter_launcher_if;
  logic       btn;
  logic       done;
  logic       err_clr;
  logic       go;
  logic       busy;
  logic       timeout_err;
  logic [7:0] run_count;

  modport master (
    input  btn,
    input  done,
    input  err_clr,
    output go,
    output busy,
    output timeout_err,
    output run_count
  );

  modport slave (
    output btn,
    output done,
    output err_clr,
    input  go,
    input  busy,
    input  timeout_err,
    input  run_count
  );
endinterface

`default_nettype wire

// File: rtl/counter_launcher.sv
// ============================================================================
// counter_launcher : debounced button -> single go pulse, waits for done
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_launcher #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned TIMEOUT_CYCLES  = 64
) (
  input  wire logic          clk,
  input  wire logic          rst,
  counter_launcher_if.master bus
);

  localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        sync1_q, sync2_q;
  logic        stable_q, stable_d;
  logic        stable_dly_q;
  logic [15:0] db_cnt_q, db_cnt_d;
  logic [15:0] to_cnt_q, to_cnt_d;
  logic [7:0]  run_count_q, run_count_d;
  logic        timeout_err_q, timeout_err_d;
  logic        press;
  logic        expire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      stable_q      <= 1'b0;
      stable_dly_q  <= 1'b0;
      db_cnt_q      <= '0;
      to_cnt_q      <= '0;
      run_count_q   <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= bus.btn;
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      stable_dly_q  <= stable_q;
      db_cnt_q      <= db_cnt_d;
      to_cnt_q      <= to_cnt_d;
      run_count_q   <= run_count_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Stable value only flips after the synchronized input disagrees for
  // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
  always_comb begin
    stable_d = stable_q;
    db_cnt_d = '0;
    if (sync2_q != stable_q) begin
      if (db_cnt_q == DB_LAST) begin
        stable_d = ~stable_q;
      end else begin
        db_cnt_d = db_cnt_q + 16'd1;
      end
    end
  end

  assign press = stable_q & ~stable_dly_q;

  always_comb begin
    state_d       = state_q;
    to_cnt_d      = to_cnt_q;
    run_count_d   = run_count_q;
    timeout_err_d = timeout_err_q;
    expire        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (press) begin
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        state_d  = ST_WAIT_DONE;
        to_cnt_d = '0;
      end
      ST_WAIT_DONE: begin
        // done takes priority over a coincident timeout expiry
        if (bus.done) begin
          state_d     = ST_IDLE;
          run_count_d = run_count_q + 8'd1;
        end else if (to_cnt_q == TO_LAST) begin
          state_d = ST_IDLE;
          expire  = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (expire) begin
      timeout_err_d = 1'b1;
    end else if (bus.err_clr) begin
      timeout_err_d = 1'b0;
    end
  end

  assign bus.go          = (state_q == ST_LAUNCH);
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.timeout_err = timeout_err_q;
  assign bus.run_count   = run_count_q;

endmodule

`default_nettype wire

// File: tb/tb_counter_launcher.sv
// ============================================================================
// tb_counter_launcher : directed self-checking bench for counter_launcher
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_counter_launcher;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   go_count;
  int   exp_runs;

  counter_launcher_if bus ();

  counter_launcher #(
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.go === 1'b1) go_count++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Raise btn and count edges until go appears; -1 when go never comes.
  task automatic do_press(output int lat);
    bus.btn = 1'b1;
    lat = -1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (bus.go === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.btn = 1'b1; bus.done = 1'b1; bus.err_clr = 1'b0;
    ticks(3);
    checks++; if (bus.go !== 1'b0) begin errors++; $display("FAIL rst_go: got %b want 0", bus.go); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", bus.timeout_err); end
    checks++; if (bus.run_count !== 8'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", bus.run_count); end
    bus.btn = 1'b0; bus.done = 1'b0; rst = 1'b0;
    ticks(8);
    checks++; if (bus.go !== 1'b0) begin errors++; $display("FAIL post_rst_go: got %b want 0", bus.go); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL post_rst_busy: got %b want 0", bus.busy); end
    checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL post_rst_err: got %b want 0", bus.timeout_err); end
    checks++; if (bus.run_count !== 8'd0) begin errors++; $display("FAIL post_rst_count: got %0d want 0", bus.run_count); end
  endtask

  task automatic test_press_done();
    int lat;
    int g0;
    g0 = go_count;
    do_press(lat);
    checks++; if (lat !== 7) begin errors++; $display("FAIL press_latency: got %0d want 7", lat); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL busy_at_go: got %b want 1", bus.busy); end
    tick();
    checks++; if (bus.go !== 1'b0) begin errors++; $display("FAIL go_width: got %b want 0", bus.go); end
    ticks(4);
    bus.done = 1'b1;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL busy_at_done: got %b want 1", bus.busy); end
    tick();
    bus.done = 1'b0;
    exp_runs++;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL busy_after_done: got %b want 0", bus.busy); end
    checks++; if (bus.run_count !== 8'(exp_runs)) begin errors++; $display("FAIL run_count_1: got %0d want %0d", bus.run_count, exp_runs); end
    ticks(7);
    bus.btn = 1'b0;
    ticks(12);
    checks++; if (go_count - g0 !== 1) begin errors++; $display("FAIL single_go: got %0d want 1", go_count - g0); end
  endtask

  task automatic test_glitch_reject();
    int g0;
    g0 = go_count;
    for (int r = 0; r < 5; r++) begin
      bus.btn = 1'b1;
      ticks(3);
      bus.btn = 1'b0;
      ticks(6);
    end
    checks++; if (go_count - g0 !== 0) begin errors++; $display("FAIL glitch_go: got %0d want 0", go_count - g0); end
    checks++; if (bus.run_count !== 8'(exp_runs)) begin errors++; $display("FAIL glitch_count: got %0d want %0d", bus.run_count, exp_runs); end
  endtask

  task automatic test_timeout();
    int lat;
    int n;
    do_press(lat);
    bus.btn = 1'b0;
    checks++; if (lat !== 7) begin errors++; $display("FAIL to_latency: got %0d want 7", lat); end
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.busy === 1'b0) begin
        n = i;
        break;
      end
    end
    checks++; if (n !== 9) begin errors++; $display("FAIL to_busy_drop: got %0d want 9", n); end
    checks++; if (bus.timeout_err !== 1'b1) begin errors++; $display("FAIL to_err_set: got %b want 1", bus.timeout_err); end
    checks++; if (bus.run_count !== 8'(exp_runs)) begin errors++; $display("FAIL to_count: got %0d want %0d", bus.run_count, exp_runs); end
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL err_clr: got %b want 0", bus.timeout_err); end
    ticks(10);
    do_press(lat);
    bus.btn = 1'b0;
    checks++; if (lat !== 7) begin errors++; $display("FAIL to2_latency: got %0d want 7", lat); end
    ticks(8);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL to2_busy: got %b want 1", bus.busy); end
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    checks++; if (bus.timeout_err !== 1'b1) begin errors++; $display("FAIL set_beats_clr: got %b want 1", bus.timeout_err); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL to2_idle: got %b want 0", bus.busy); end
  endtask

  // Second debounced press lands on WAIT_DONE cycle 7; done on cycle 8
  // coincides with timeout expiry.
  task automatic test_back_to_back();
    int g0;
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    ticks(10);
    g0 = go_count;
    bus.btn = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 4) bus.btn = 1'b0;
      if (k == 8) bus.btn = 1'b1;
      if (k == 7) begin
        checks++; if (bus.go !== 1'b1) begin errors++; $display("FAIL b2b_go: got %b want 1", bus.go); end
      end
      if (k == 15) begin
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_w8: got %b want 1", bus.busy); end
        bus.done = 1'b1;
      end
      if (k == 16) bus.done = 1'b0;
    end
    exp_runs++;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b want 0", bus.busy); end
    checks++; if (bus.run_count !== 8'(exp_runs)) begin errors++; $display("FAIL b2b_count: got %0d want %0d", bus.run_count, exp_runs); end
    checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL done_beats_to: got %b want 0", bus.timeout_err); end
    bus.btn = 1'b0;
    ticks(12);
    checks++; if (go_count - g0 !== 1) begin errors++; $display("FAIL b2b_go_count: got %0d want 1", go_count - g0); end
  endtask

  task automatic test_wrap_and_reset();
    int lat;
    int g0;
    int n;
    int bad;
    n = 255 - exp_runs;
    bad = 0;
    for (int r = 0; r < n; r++) begin
      do_press(lat);
      bus.btn = 1'b0;
      if (lat != 7) bad++;
      tick();
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
      ticks(8);
      exp_runs++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL preload_runs: got %0d bad launches want 0", bad); end
    checks++; if (bus.run_count !== 8'd255) begin errors++; $display("FAIL count_255: got %0d want 255", bus.run_count); end
    do_press(lat);
    bus.btn = 1'b0;
    tick();
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    checks++; if (bus.run_count !== 8'd0) begin errors++; $display("FAIL count_wrap: got %0d want 0", bus.run_count); end
    ticks(10);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    do_press(lat);
    ticks(3);
    g0 = go_count;
    rst = 1'b1;
    bus.btn = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL async_rst_busy: got %b want 0", bus.busy); end
    checks++; if (bus.run_count !== 8'd0) begin errors++; $display("FAIL async_rst_count: got %0d want 0", bus.run_count); end
    tick();
    rst = 1'b0;
    ticks(20);
    checks++; if (go_count - g0 !== 0) begin errors++; $display("FAIL go_after_rst: got %0d want 0", go_count - g0); end
    checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL err_after_rst: got %b want 0", bus.timeout_err); end
  endtask

  initial begin
    errors = 0; checks = 0; go_count = 0; exp_runs = 0;
    rst = 1'b1;
    bus.btn = 1'b0; bus.done = 1'b0; bus.err_clr = 1'b0;
    test_reset();
    test_press_done();
    test_glitch_reject();
    test_timeout();
    test_back_to_back();
    test_wrap_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
